// File: rtl/edma_rsp.sv
// rtl/edma_rsp.sv - emesh request slave to single-port memory with ordered read-response queue
module edma_rsp #(
    parameter int AW = 32,
    parameter int PW = 2 * AW + 40
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          access_in,
    input  logic [PW-1:0] packet_in,
    output logic          wait_out,
    output logic          access_out,
    output logic [PW-1:0] packet_out,
    input  logic          wait_in,
    output logic          mem_en,
    output logic          mem_we,
    output logic [3:0]    mem_wstrb,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          err
);

    // request fields
    logic        w_write;
    logic [1:0]  w_mode;
    logic [4:0]  w_ctrl;
    logic [31:0] w_dst;
    logic [31:0] w_data;
    logic [31:0] w_src;
    logic [1:0]  w_off;
    logic        w_aligned;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic [2:0]  w_occupancy;
    logic [31:0] w_shift;
    logic [31:0] w_rsp_data;
    logic [PW-1:0] w_rsp_pkt;

    // read context captured at accept, consumed one cycle later when rdata is valid
    logic        r_inflight;
    logic [1:0]  r_rd_mode;
    logic [4:0]  r_rd_ctrl;
    logic [31:0] r_rd_src;
    logic [1:0]  r_rd_off;
    logic        r_rd_aligned;

    // two-entry response queue
    logic [PW-1:0] r_fifo [2];
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_count;
    logic          r_err;

    assign w_write = packet_in[0];
    assign w_mode  = packet_in[2:1];
    assign w_ctrl  = packet_in[7:3];
    assign w_dst   = packet_in[39:8];
    assign w_data  = packet_in[71:40];
    assign w_src   = packet_in[103:72];
    assign w_off   = w_dst[1:0];

    // Reads in flight count against the queue so a response always has a slot
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight};
    assign wait_out    = ~reset & (w_occupancy >= 3'd2);
    assign w_accept    = access_in & ~wait_out & ~reset;

    assign mem_en    = w_accept;
    assign mem_we    = w_accept & w_write & w_aligned;
    assign mem_addr  = {w_dst[31:2], 2'b00};
    assign mem_wdata = w_data << {w_off, 3'b000};

    assign w_push     = r_inflight;
    assign access_out = ~reset & (r_count != 2'd0);
    assign w_pop      = access_out & ~wait_in;
    assign packet_out = r_fifo[r_rptr];
    assign err        = r_err;

    // alignment check and byte-lane strobes from datamode and low address bits
    always_comb begin
        w_aligned = 1'b0;
        mem_wstrb = 4'b0000;
        case (w_mode)
            2'd0: begin
                w_aligned = 1'b1;
                mem_wstrb = 4'b0001 << w_off;
            end
            2'd1: begin
                w_aligned = ~w_dst[0];
                mem_wstrb = 4'b0011 << w_off;
            end
            2'd2: begin
                w_aligned = (w_off == 2'd0);
                mem_wstrb = 4'b1111;
            end
            default: begin
                w_aligned = 1'b0;
                mem_wstrb = 4'b0000;
            end
        endcase
    end

    // response data: shift the addressed lane down, trim to datamode width, zero if misaligned
    always_comb begin
        w_shift    = mem_rdata >> {r_rd_off, 3'b000};
        w_rsp_data = 32'd0;
        if (r_rd_aligned) begin
            case (r_rd_mode)
                2'd0:    w_rsp_data = {24'd0, w_shift[7:0]};
                2'd1:    w_rsp_data = {16'd0, w_shift[15:0]};
                2'd2:    w_rsp_data = w_shift;
                default: w_rsp_data = 32'd0;
            endcase
        end
        w_rsp_pkt = {32'd0, w_rsp_data, r_rd_src, r_rd_ctrl, r_rd_mode, 1'b1};
    end

    // control state: in-flight flag, queue pointers/count and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight <= 1'b0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_count    <= 2'd0;
            r_err      <= 1'b0;
        end else begin
            r_inflight <= w_accept & ~w_write;
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_accept & ~w_aligned) r_err <= 1'b1;
        end
    end

    // datapath registers: read context and queue storage need no reset
    always_ff @(posedge clk) begin
        if (w_accept & ~w_write) begin
            r_rd_mode    <= w_mode;
            r_rd_ctrl    <= w_ctrl;
            r_rd_src     <= w_src;
            r_rd_off     <= w_off;
            r_rd_aligned <= w_aligned;
        end
        if (w_push) r_fifo[r_wptr] <= w_rsp_pkt;
    end

endmodule

// File: tb/tb_edma_rsp.sv
// tb/tb_edma_rsp.sv - self-checking bench for edma_rsp with byte-level memory reference model
module tb_edma_rsp;

    logic         clk = 1'b0;
    logic         reset;
    logic         access_in;
    logic [103:0] packet_in;
    logic         wait_out;
    logic         access_out;
    logic [103:0] packet_out;
    logic         wait_in;
    logic         mem_en;
    logic         mem_we;
    logic [3:0]   mem_wstrb;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         err;

    int total = 0;
    int bad   = 0;

    bit [31:0] tmem  [0:255];
    bit [7:0]  ref_b [0:1023];

    always #5 clk = ~clk;

    edma_rsp dut (
        .clk(clk), .reset(reset), .access_in(access_in), .packet_in(packet_in),
        .wait_out(wait_out), .access_out(access_out), .packet_out(packet_out),
        .wait_in(wait_in), .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err(err)
    );

    // memory seen by the DUT: byte-strobed writes, read data one cycle after the strobe
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int i = 0; i < 4; i++)
                    if (mem_wstrb[i]) tmem[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
            end else begin
                mem_rdata <= tmem[mem_addr[9:2]];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic logic [103:0] pkt(input logic w, input logic [1:0] md, input logic [4:0] ct,
                                         input logic [31:0] dst, input logic [31:0] dat,
                                         input logic [31:0] src);
        return {src, dat, dst, ct, md, w};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        access_in = 1'b0;
        packet_in = '0;
    endtask

    task automatic test_reset;
        reset = 1'b1; wait_in = 1'b0;
        access_in = 1'b1; packet_in = pkt(0, 2, 0, 32'h100, 0, 32'h77);
        step;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if ({wait_out, access_out, mem_en, mem_we, err} !== 5'b0) begin
                bad++;
                $display("FAIL reset_hold got={wait,acc,en,we,err}=%b exp=00000",
                         {wait_out, access_out, mem_en, mem_we, err});
            end
            step;
        end
        reset = 1'b0; idle;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (access_out !== 1'b0 || wait_out !== 1'b0) begin
                bad++;
                $display("FAIL reset_after got acc=%b wait=%b exp 0 0", access_out, wait_out);
            end
            step;
        end
    endtask

    task automatic test_word;
        access_in = 1'b1; packet_in = pkt(1, 2, 0, 32'h100, 32'hDEADBEEF, 0);
        @(negedge clk);
        total++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1) begin
            bad++; $display("FAIL word_wr_en got en=%b we=%b exp 1 1", mem_en, mem_we);
        end
        total++;
        if (mem_wstrb !== 4'b1111) begin
            bad++; $display("FAIL word_wstrb got=%b exp=1111", mem_wstrb);
        end
        total++;
        if (mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h100) begin
            bad++; $display("FAIL word_wdata got=%h@%h exp=deadbeef@00000100", mem_wdata, mem_addr);
        end
        step;
        packet_in = pkt(0, 2, 0, 32'h100, 0, 32'h80000040);
        @(negedge clk);
        total++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || wait_out !== 1'b0) begin
            bad++; $display("FAIL word_rd_accept got en=%b we=%b wait=%b exp 1 0 0", mem_en, mem_we, wait_out);
        end
        step; idle;
        @(negedge clk);
        total++;
        if (access_out !== 1'b0) begin
            bad++; $display("FAIL word_lat1 got access_out=%b exp=0", access_out);
        end
        step;
        @(negedge clk);
        total++;
        if (access_out !== 1'b1) begin
            bad++; $display("FAIL word_lat2 got access_out=%b exp=1", access_out);
        end
        total++;
        if (packet_out !== pkt(1, 2, 0, 32'h80000040, 32'hDEADBEEF, 0)) begin
            bad++; $display("FAIL word_rsp got=%h exp=%h", packet_out, pkt(1, 2, 0, 32'h80000040, 32'hDEADBEEF, 0));
        end
        step;
        @(negedge clk);
        total++;
        if (access_out !== 1'b0) begin
            bad++; $display("FAIL word_pop got access_out=%b exp=0", access_out);
        end
        step;
    endtask

    task automatic test_byte;
        access_in = 1'b1; packet_in = pkt(1, 2, 0, 32'h100, 32'hAABBCCDD, 0);
        step;
        packet_in = pkt(0, 0, 5, 32'h102, 0, 32'h1234);
        step; idle;
        step;
        @(negedge clk);
        total++;
        if (access_out !== 1'b1 || packet_out !== pkt(1, 0, 5, 32'h1234, 32'h000000BB, 0)) begin
            bad++; $display("FAIL byte_rd got acc=%b pkt=%h exp=%h", access_out, packet_out,
                            pkt(1, 0, 5, 32'h1234, 32'h000000BB, 0));
        end
        step;
        access_in = 1'b1; packet_in = pkt(1, 0, 0, 32'h103, 32'h5A, 0);
        @(negedge clk);
        total++;
        if (mem_wstrb !== 4'b1000 || mem_wdata !== 32'h5A000000 || mem_we !== 1'b1) begin
            bad++; $display("FAIL byte_wr got wstrb=%b wdata=%h we=%b exp 1000 5a000000 1",
                            mem_wstrb, mem_wdata, mem_we);
        end
        step; idle;
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_dst [0:2];
        exp_dst[0] = 32'h10; exp_dst[1] = 32'h20; exp_dst[2] = 32'h30;
        wait_in = 1'b1; access_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            packet_in = pkt(0, 2, 0, 32'h100, 0, exp_dst[i]);
            @(negedge clk);
            total++;
            if (wait_out !== (i == 2)) begin
                bad++; $display("FAIL bp_wait%0d got=%b exp=%b", i, wait_out, (i == 2));
            end
            step;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (wait_out !== 1'b1 || access_out !== 1'b1 || packet_out[39:8] !== exp_dst[0]) begin
                bad++; $display("FAIL bp_hold got wait=%b acc=%b dst=%h exp 1 1 %h",
                                wait_out, access_out, packet_out[39:8], exp_dst[0]);
            end
            step;
        end
        wait_in = 1'b0;
        @(negedge clk);
        total++;
        if (wait_out !== 1'b1 || packet_out[39:8] !== exp_dst[0]) begin
            bad++; $display("FAIL bp_pop1 got wait=%b dst=%h exp 1 %h", wait_out, packet_out[39:8], exp_dst[0]);
        end
        step;
        wait_in = 1'b1;
        @(negedge clk);
        total++;
        if (wait_out !== 1'b0 || packet_out[39:8] !== exp_dst[1]) begin
            bad++; $display("FAIL bp_third got wait=%b dst=%h exp 0 %h", wait_out, packet_out[39:8], exp_dst[1]);
        end
        step; idle; wait_in = 1'b0;
        @(negedge clk);
        total++;
        if (wait_out !== 1'b1 || access_out !== 1'b1 || packet_out[39:8] !== exp_dst[1]) begin
            bad++; $display("FAIL bp_second got wait=%b acc=%b dst=%h exp 1 1 %h",
                            wait_out, access_out, packet_out[39:8], exp_dst[1]);
        end
        step;
        @(negedge clk);
        total++;
        if (access_out !== 1'b1 || packet_out[39:8] !== exp_dst[2]) begin
            bad++; $display("FAIL bp_last got acc=%b dst=%h exp 1 %h", access_out, packet_out[39:8], exp_dst[2]);
        end
        step;
        @(negedge clk);
        total++;
        if (access_out !== 1'b0) begin
            bad++; $display("FAIL bp_drain got access_out=%b exp=0", access_out);
        end
        step;
    endtask

    task automatic test_misalign;
        wait_in = 1'b0;
        access_in = 1'b1; packet_in = pkt(0, 2, 0, 32'h101, 0, 32'h44);
        step; idle;
        @(negedge clk);
        total++;
        if (err !== 1'b1) begin
            bad++; $display("FAIL mis_err got=%b exp=1", err);
        end
        step;
        @(negedge clk);
        total++;
        if (access_out !== 1'b1 || packet_out !== pkt(1, 2, 0, 32'h44, 0, 0)) begin
            bad++; $display("FAIL mis_rsp got acc=%b pkt=%h exp=%h", access_out, packet_out, pkt(1, 2, 0, 32'h44, 0, 0));
        end
        step;
        access_in = 1'b1; packet_in = pkt(1, 1, 0, 32'h101, 32'h1234, 0);
        @(negedge clk);
        total++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0) begin
            bad++; $display("FAIL mis_half got en=%b we=%b exp 1 0", mem_en, mem_we);
        end
        step; idle;
        @(negedge clk);
        total++;
        if (err !== 1'b1) begin
            bad++; $display("FAIL mis_sticky got=%b exp=1", err);
        end
        step;
    endtask

    task automatic test_reset_mid;
        reset = 1'b1; step; reset = 1'b0;
        access_in = 1'b1; packet_in = pkt(0, 2, 0, 32'h100, 0, 32'h99);
        @(negedge clk);
        total++;
        if (err !== 1'b0 || wait_out !== 1'b0 || mem_en !== 1'b1) begin
            bad++; $display("FAIL rst_pre got err=%b wait=%b en=%b exp 0 0 1", err, wait_out, mem_en);
        end
        step;
        reset = 1'b1; idle;
        @(negedge clk);
        total++;
        if (access_out !== 1'b0) begin
            bad++; $display("FAIL rst_during got access_out=%b exp=0", access_out);
        end
        step;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (access_out !== 1'b0 || err !== 1'b0) begin
                bad++; $display("FAIL rst_after%0d got acc=%b err=%b exp 0 0", i, access_out, err);
            end
            step;
        end
    endtask

    task automatic test_random;
        logic [103:0] q[$];
        bit err_m;
        reset = 1'b1; idle; wait_in = 1'b0;
        step;
        reset = 1'b0; err_m = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic        w;
            logic [1:0]  md;
            logic [4:0]  ct;
            logic [31:0] dst, dat, src, rd, exp_strb32;
            logic [9:0]  a;
            bit          acc, al;
            access_in = ($urandom_range(0, 9) < 7);
            wait_in   = ($urandom_range(0, 9) < 3);
            w   = 1'($urandom_range(0, 1));
            md  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            dst = 32'h200 | 32'($urandom_range(0, 511));
            dat = $urandom;
            src = $urandom;
            ct  = 5'($urandom);
            packet_in = pkt(w, md, ct, dst, dat, src);
            a   = dst[9:0];
            al  = (md == 2'd0) || (md == 2'd1 && a % 2 == 0) || (md == 2'd2 && a % 4 == 0);
            @(negedge clk);
            total++;
            if (wait_out !== (q.size() >= 2)) begin
                bad++; $display("FAIL rnd_wait c=%0d got=%b exp=%b", c, wait_out, (q.size() >= 2));
            end
            total++;
            if (err !== err_m) begin
                bad++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, err, err_m);
            end
            acc = access_in && (q.size() < 2);
            total++;
            if (mem_en !== acc) begin
                bad++; $display("FAIL rnd_en c=%0d got=%b exp=%b", c, mem_en, acc);
            end
            if (dut.r_inflight) begin
                total++;
                if (dut.r_count == 2'd2 && !(access_out && !wait_in)) begin
                    bad++; $display("FAIL rnd_overflow c=%0d got count=%0d with push exp no push when full", c, dut.r_count);
                end
            end
            if (acc && w) begin
                total++;
                if (mem_we !== al || mem_addr !== {dst[31:2], 2'b00}) begin
                    bad++; $display("FAIL rnd_we c=%0d got we=%b addr=%h exp %b %h", c, mem_we, mem_addr, al, {dst[31:2], 2'b00});
                end
                if (md != 2'd3) begin
                    exp_strb32 = (md == 2'd0) ? 32'h1 : (md == 2'd1) ? 32'h3 : 32'hF;
                    exp_strb32 = (md == 2'd2) ? 32'hF : (exp_strb32 << a[1:0]);
                    total++;
                    if (mem_wstrb !== exp_strb32[3:0] || mem_wdata !== (dat << (8 * a[1:0]))) begin
                        bad++; $display("FAIL rnd_wr c=%0d got strb=%b wdata=%h exp %b %h", c, mem_wstrb,
                                        mem_wdata, exp_strb32[3:0], dat << (8 * a[1:0]));
                    end
                end
                if (al) begin
                    ref_b[a] = dat[7:0];
                    if (md >= 2'd1) ref_b[a + 1] = dat[15:8];
                    if (md == 2'd2) begin
                        ref_b[a + 2] = dat[23:16];
                        ref_b[a + 3] = dat[31:24];
                    end
                end
            end
            if (acc && !w) begin
                total++;
                if (mem_we !== 1'b0) begin
                    bad++; $display("FAIL rnd_rd_we c=%0d got=%b exp=0", c, mem_we);
                end
            end
            if (acc && !al) err_m = 1'b1;
            if (access_out === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rnd_spurious c=%0d got pkt=%h exp no response", c, packet_out);
                end else if (packet_out !== q[0]) begin
                    bad++; $display("FAIL rnd_rsp c=%0d got=%h exp=%h", c, packet_out, q[0]);
                end
                if (!wait_in && q.size() > 0) void'(q.pop_front());
            end
            if (acc && !w) begin
                rd = 32'd0;
                if (al) begin
                    if (md == 2'd0) rd = {24'd0, ref_b[a]};
                    if (md == 2'd1) rd = {16'd0, ref_b[a + 1], ref_b[a]};
                    if (md == 2'd2) rd = {ref_b[a + 3], ref_b[a + 2], ref_b[a + 1], ref_b[a]};
                end
                q.push_back(pkt(1, md, ct, src, rd, 0));
            end
            step;
        end
        idle; wait_in = 1'b0;
        for (int c = 0; c < 20 && q.size() > 0; c++) begin
            @(negedge clk);
            if (access_out === 1'b1) begin
                total++;
                if (packet_out !== q[0]) begin
                    bad++; $display("FAIL rnd_drain got=%h exp=%h", packet_out, q[0]);
                end
                void'(q.pop_front());
            end
            step;
        end
        total++;
        if (q.size() != 0) begin
            bad++; $display("FAIL rnd_leftover got %0d responses missing exp 0", q.size());
        end
    endtask

    initial begin
        reset = 1'b1; access_in = 1'b0; packet_in = '0; wait_in = 1'b0;
        test_reset;
        test_word;
        test_byte;
        test_backpressure;
        test_misalign;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/edma_rsp.md
EDMA_RSP -- requirements
Module: edma_rsp

Interface
REQ-001 The parameter AW SHALL have default 32 and is the emesh address/data width; only 32 is supported.
REQ-002 The parameter PW SHALL have default 2*AW+40 (104) and is the emesh packet width.
REQ-003 Packet layout SHALL be: [0] write, [2:1] datamode, [7:3] ctrlmode, [39:8] dstaddr, [71:40] data, [103:72] srcaddr.
REQ-004 clk  in  1  main clock; the block has one clock, and all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 access_in  in  1  request valid from the edma master side.
REQ-007 packet_in  in  PW  request packet: write, or read with return address in srcaddr.
REQ-008 wait_out  out  1  pushback to the requester; the request is not accepted while high.
REQ-009 access_out  out  1  read-response valid.
REQ-010 packet_out  out  PW  read-response packet.
REQ-011 wait_in  in  1  pushback on the response port.
REQ-012 mem_en  out  1  memory access strobe.
REQ-013 mem_we  out  1  memory write enable, qualified by mem_en.
REQ-014 mem_wstrb  out  4  byte write strobes.
REQ-015 mem_addr  out  AW  word address, {dstaddr[31:2],2'b00}.
REQ-016 mem_wdata  out  32  write data.
REQ-017 mem_rdata  in  32  read data, valid exactly 1 cycle after mem_en with mem_we=0.
REQ-018 err  out  1  sticky misalignment/unsupported-datamode flag.

Function
REQ-019 A request SHALL be accepted in a cycle where access_in=1 and wait_out=0; acceptance is "accept".
REQ-020 A request is aligned only if one of these holds: datamode 0 (byte); datamode 1 (half) with dstaddr[0]=0; datamode 2 (word) with dstaddr[1:0]=0. Datamode 3 SHALL be treated as misaligned.
REQ-021 Handling of an accepted write (write=1) SHALL be:
- mem_en=1 in the same cycle, combinationally from accept.
- mem_we = aligned.
- mem_wstrb: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
- mem_wdata = data shifted left by 8*addr[1:0].
- No response is generated.
REQ-022 An accepted read (write=0) SHALL assert mem_en=1 with mem_we=0 in the accept cycle and SHALL set an in-flight flag for one cycle, registering datamode, ctrlmode, srcaddr, addr[1:0] and aligned.
REQ-023 In the cycle after a read is accepted, the response SHALL be pushed into a 2-entry FIFO:
- write=1, same datamode and ctrlmode.
- dstaddr = request srcaddr.
- srcaddr = 0.
- data = mem_rdata >> 8*addr[1:0], zero-extended to the datamode width, or 0 if misaligned.
REQ-024 access_out SHALL equal FIFO-not-empty and packet_out SHALL equal the FIFO head; the head pops when access_out=1 and wait_in=0, and packet_out is held stable while wait_in=1.
REQ-025 Read latency SHALL be 2 cycles from accept to access_out when the FIFO is empty, and responses SHALL leave in acceptance order.
REQ-026 wait_out SHALL be high when fifo_count + inflight >= 2; it is combinational from registered state only and never depends on access_in.
REQ-027 wait_out SHALL block writes as well as reads, so that ordering is preserved.
REQ-028 A push and a pop in the same cycle SHALL leave the count unchanged; a push when fifo_count=2 cannot occur by REQ-026, and the bench SHALL assert that it never does.
REQ-029 Any accepted misaligned request SHALL set err=1, which stays set until reset.

Reset
REQ-030 While reset=1, the following SHALL be held: fifo_count=0, inflight=0, err=0, access_out=0, wait_out=0, mem_en=0, mem_we=0.
REQ-031 A reset asserted mid-operation SHALL discard in-flight reads and queued responses, and no response from before reset SHALL appear afterwards.
REQ-032 A request presented in the reset cycle SHALL NOT be accepted.

Verification
REQ-033 Word write then read: write dstaddr=0x100, data=0xDEADBEEF, mode 2, followed by a read of 0x100 with srcaddr=0x8000_0040 -> mem_wstrb=1111, then access_out 2 cycles after the read accept, with packet dstaddr=0x80000040, data=0xDEADBEEF, write=1.
REQ-034 Byte read: mem_rdata=0xAABBCCDD, read of addr 0x102, mode 0 -> data=0x000000BB; byte write of 0x5A to 0x103 -> wstrb=1000, wdata=0x5A000000.
REQ-035 Backpressure: hold wait_in=1 and issue 3 back-to-back reads -> 2 accepted, wait_out=1 from the cycle after the second accept, third accepted only after the first pop, and responses arrive in order.
REQ-036 Misalignment: word read at 0x101 -> err=1, response data=0; half write at 0x101 -> mem_we=0, err stays 1.
REQ-037 Reset mid-flight: a read is accepted and reset is asserted the next cycle -> access_out=0 throughout and after reset, and err=0.
